// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with ready/active/done handshake
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [DATA_BITS-1:0] i_Data_Byte,
    input  logic                 i_TX_DV,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Ready,
    output logic                 o_TX_Active,
    output logic                 o_TX_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic STOP_LAST  = (STOP_BITS == 2);
    // Mode 3 is treated as "no parity"
    localparam logic HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam logic ODD_PARITY = (PARITY_MODE == 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 3) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_MODE must be 0..3");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d;
    logic                   done_q, done_d;
    logic                   line_q, line_d;

    // State and datapath registers; the line is registered from the next-state view
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            par_q   <= par_d;
            done_q  <= done_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic, bit timing and the value the line will carry next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        par_d   = par_q;
        done_d  = 1'b0;
        line_d  = 1'b1;

        case (state_q)
            IDLE: begin
                if (i_TX_DV) begin
                    data_d  = i_Data_Byte;
                    par_d   = ODD_PARITY ? ~^i_Data_Byte : ^i_Data_Byte;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        stop_d  = 1'b0;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = data_d[idx_d];
            PARITY:  line_d = par_d;
            default: line_d = 1'b1;
        endcase
    end

    assign o_TX_Serial = line_q;
    assign o_TX_Ready  = (state_q == IDLE);
    assign o_TX_Active = (state_q != IDLE);
    assign o_TX_Done   = done_q;

endmodule
